// File: rtl/b03_req_agent.sv
// Requester-side agent for a 4-way round-robin arbiter: queues jobs per channel, requests,
// holds the resource for HOLD_CYCLES, then releases with a one-cycle gap. Optional protocol checker: B03_REQ_PROTO_CHECK_EN.
module b03_req_agent #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned JOB_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] job_valid_i,
  input  logic [3:0] grant_i,
  output logic [3:0] request_o,
  output logic [3:0] busy_o,
  output logic [3:0] done_o,
  output logic [3:0] timeout_o,
  output logic [3:0] ovf_o,
  output logic [7:0] jobs_done_o
`ifdef B03_REQ_PROTO_CHECK_EN
  ,
  output logic       proto_err_o
`endif
);

  // Request/grant handshake: request_o[i] stays high from REQ through USE; the arbiter's
  // one-hot grant_i[i] is honoured only in REQ (to start) and USE (to continue). Dropping
  // request_o[i] for one GAP cycle is the release.
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_USE, ST_GAP} state_e;

  localparam logic [JOB_W-1:0] PEND_MAX  = '1;
  localparam logic [15:0]      WAIT_LIM  = 16'(TIMEOUT);
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_e           state_q [4];
  state_e           state_d [4];
  logic [JOB_W-1:0] pend_q  [4];
  logic [JOB_W-1:0] pend_d  [4];
  logic [15:0]      wait_q  [4];
  logic [15:0]      wait_d  [4];
  logic [7:0]       hold_q  [4];
  logic [7:0]       hold_d  [4];
  logic [3:0]       req_q, req_d, busy_q, busy_d, done_q, done_d;
  logic [3:0]       tmo_q, tmo_d, ovf_q, ovf_d;
  logic [7:0]       jobs_q, jobs_d;

  always_comb begin
    jobs_d = jobs_q;
    req_d  = '0;
    busy_d = '0;
    done_d = '0;
    tmo_d  = tmo_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      pend_d[i]  = pend_q[i];
      wait_d[i]  = '0;
      hold_d[i]  = hold_q[i];
      case (state_q[i])
        ST_IDLE: if (pend_q[i] != '0) state_d[i] = ST_REQ;
        ST_REQ: begin
          if (grant_i[i]) begin
            state_d[i] = ST_USE;
            hold_d[i]  = HOLD_LOAD;
          end else begin
            // Saturate so a very long wait cannot wrap back below the limit.
            wait_d[i] = (wait_q[i] == WAIT_LIM) ? wait_q[i] : wait_q[i] + 16'd1;
            if (wait_d[i] >= WAIT_LIM) tmo_d[i] = 1'b1;
          end
        end
        ST_USE: begin
          if (hold_q[i] == 8'd0) begin
            state_d[i] = ST_GAP;
            done_d[i]  = 1'b1;
          end else if (!grant_i[i]) begin
            state_d[i] = ST_GAP;
          end else begin
            hold_d[i] = hold_q[i] - 8'd1;
          end
        end
        ST_GAP:  state_d[i] = (pend_q[i] != '0) ? ST_REQ : ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
      // An enqueue coinciding with a completion leaves the count untouched.
      if (job_valid_i[i] && !done_d[i]) begin
        if (pend_q[i] == PEND_MAX) ovf_d[i] = 1'b1;
        else                       pend_d[i] = pend_q[i] + 1'b1;
      end else if (!job_valid_i[i] && done_d[i]) begin
        pend_d[i] = pend_q[i] - 1'b1;
      end
      req_d[i]  = (state_d[i] == ST_REQ) || (state_d[i] == ST_USE);
      busy_d[i] = (state_d[i] == ST_USE);
      jobs_d    = jobs_d + {7'd0, done_d[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_IDLE;
        pend_q[i]  <= '0;
        wait_q[i]  <= '0;
        hold_q[i]  <= '0;
      end
      req_q  <= '0;
      busy_q <= '0;
      done_q <= '0;
      tmo_q  <= '0;
      ovf_q  <= '0;
      jobs_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        pend_q[i]  <= pend_d[i];
        wait_q[i]  <= wait_d[i];
        hold_q[i]  <= hold_d[i];
      end
      req_q  <= req_d;
      busy_q <= busy_d;
      done_q <= done_d;
      tmo_q  <= tmo_d;
      ovf_q  <= ovf_d;
      jobs_q <= jobs_d;
    end
  end

  assign request_o   = req_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign timeout_o   = tmo_q;
  assign ovf_o       = ovf_q;
  assign jobs_done_o = jobs_q;

`ifdef B03_REQ_PROTO_CHECK_EN
  logic       proto_q, proto_d;
  logic [3:0] gap_prev_q;

  // A grant is tolerated during GAP and the cycle after it, while the arbiter catches up.
  always_comb begin
    proto_d = proto_q;
    if ((grant_i & (grant_i - 4'd1)) != 4'd0) proto_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (grant_i[i] && !req_q[i] && (state_q[i] != ST_GAP) && !gap_prev_q[i]) proto_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      proto_q    <= 1'b0;
      gap_prev_q <= '0;
    end else begin
      proto_q <= proto_d;
      for (int i = 0; i < 4; i++) gap_prev_q[i] <= (state_q[i] == ST_GAP);
    end
  end

  assign proto_err_o = proto_q;
`endif

endmodule

// File: tb/tb_b03_req_agent.sv
// Directed bench for b03_req_agent (JOB_W=2): single job, back-to-back jobs, timeout,
// preemption, overflow, async reset, and the optional protocol checker.
module tb_b03_req_agent;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] job_valid_i = '0;
  logic [3:0] grant_i = '0;
  logic [3:0] request_o, busy_o, done_o, timeout_o, ovf_o;
  logic [7:0] jobs_done_o;
`ifdef B03_REQ_PROTO_CHECK_EN
  logic       proto_err_o;
`endif

  int checks = 0;
  int failures = 0;

  b03_req_agent #(.HOLD_CYCLES(4), .TIMEOUT(64), .JOB_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .job_valid_i (job_valid_i),
    .grant_i     (grant_i),
    .request_o   (request_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .ovf_o       (ovf_o),
    .jobs_done_o (jobs_done_o)
`ifdef B03_REQ_PROTO_CHECK_EN
    ,
    .proto_err_o (proto_err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    int gap_bad;

    // Reset state
    #2;
    chk("rst_request", request_o, 4'h0);
    chk("rst_jobs", jobs_done_o, 8'd0);
    step(2);
    reset = 1'b0;
    step(1);

    // Single job on ch0, grant 3 cycles after request
    job_valid_i = 4'b0001;
    step(1);
    job_valid_i = 4'b0000;
    chk("t1_req_early", request_o, 4'h0);
    step(1);
    chk("t1_req_up", request_o, 4'b0001);
    step(2);
    grant_i = 4'b0001;
    step(1);
    chk("t1_busy_first", busy_o, 4'b0001);
    step(3);
    chk("t1_busy_last", busy_o, 4'b0001);
    chk("t1_no_done_yet", done_o, 4'h0);
    step(1);
    chk("t1_busy_off", busy_o, 4'h0);
    chk("t1_done", done_o, 4'b0001);
    chk("t1_gap_req", request_o, 4'h0);
    chk("t1_jobs", jobs_done_o, 8'd1);
    grant_i = 4'b0000;
    step(1);
    chk("t1_done_pulse", done_o, 4'h0);
    chk("t1_idle_req", request_o, 4'h0);

    // Three back-to-back jobs on ch2, grant held
    job_valid_i = 4'b0100;
    step(2);
    grant_i = 4'b0100;
    step(1);
    job_valid_i = 4'b0000;
    busy_cnt = 0;
    done_cnt = 0;
    gap_bad = 0;
    for (int k = 0; k < 30; k++) begin
      busy_cnt += int'(busy_o[2]);
      if (done_o[2]) begin
        done_cnt++;
        if (request_o[2]) gap_bad++;
        if (done_cnt == 3) grant_i = 4'b0000;
      end
      step(1);
    end
    chk("t2_busy_cycles", busy_cnt, 12);
    chk("t2_done_count", done_cnt, 3);
    chk("t2_gap_release", gap_bad, 0);
    chk("t2_jobs", jobs_done_o, 8'd4);
    chk("t2_pending", 32'(dut.pend_q[2]), 0);

    // Timeout on ch1
    job_valid_i = 4'b0010;
    step(1);
    job_valid_i = 4'b0000;
    step(1);
    chk("t3_req_up", request_o, 4'b0010);
    step(63);
    chk("t3_no_timeout", timeout_o, 4'h0);
    step(1);
    chk("t3_timeout", timeout_o, 4'b0010);
    chk("t3_still_req", request_o, 4'b0010);
    grant_i = 4'b0010;
    step(1);
    chk("t3_busy", busy_o, 4'b0010);
    step(4);
    chk("t3_done", done_o, 4'b0010);
    chk("t3_jobs", jobs_done_o, 8'd5);
    chk("t3_sticky", timeout_o, 4'b0010);
    grant_i = 4'b0000;
    step(1);

    // Preemption on ch0: grant drops on the 2nd USE cycle
    job_valid_i = 4'b0001;
    step(1);
    job_valid_i = 4'b0000;
    step(1);
    grant_i = 4'b0001;
    step(1);
    chk("t4_busy", busy_o, 4'b0001);
    step(1);
    grant_i = 4'b0000;
    step(1);
    chk("t4_preempt_busy", busy_o, 4'h0);
    chk("t4_preempt_done", done_o, 4'h0);
    chk("t4_preempt_req", request_o, 4'h0);
    chk("t4_preempt_jobs", jobs_done_o, 8'd5);
    step(1);
    chk("t4_rereq", request_o, 4'b0001);
    grant_i = 4'b0001;
    step(5);
    chk("t4_done", done_o, 4'b0001);
    chk("t4_jobs", jobs_done_o, 8'd6);
    grant_i = 4'b0000;
    step(1);

    // Overflow on ch3 (JOB_W=2), never granted
    job_valid_i = 4'b1000;
    step(3);
    chk("t5_no_ovf", ovf_o, 4'h0);
    step(2);
    job_valid_i = 4'b0000;
    chk("t5_ovf", ovf_o, 4'b1000);
    chk("t5_pending", 32'(dut.pend_q[3]), 3);
    chk("t5_req", request_o, 4'b1000);
`ifdef B03_REQ_PROTO_CHECK_EN
    chk("t5_no_proto", proto_err_o, 1'b0);
`endif

    // Asynchronous reset mid-REQ
    #2;
    reset = 1'b1;
    #1;
    chk("t6_req_drop", request_o, 4'h0);
    chk("t6_ovf_clr", ovf_o, 4'h0);
    chk("t6_tmo_clr", timeout_o, 4'h0);
    chk("t6_jobs_clr", jobs_done_o, 8'd0);
    chk("t6_pend_clr", 32'(dut.pend_q[3]), 0);
    step(1);
    reset = 1'b0;
    step(1);

`ifdef B03_REQ_PROTO_CHECK_EN
    grant_i = 4'b0110;
    step(1);
    chk("t7_multihot", proto_err_o, 1'b1);
    grant_i = 4'b0000;
    reset = 1'b1;
    #1;
    chk("t7_proto_clr", proto_err_o, 1'b0);
    step(1);
    reset = 1'b0;
    step(1);
    grant_i = 4'b0001;
    step(1);
    chk("t7_idle_grant", proto_err_o, 1'b1);
    grant_i = 4'b0000;
    step(1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
